// File: rtl/glitch_pulse_gen.sv
// glitch_pulse_gen: trigger-edge to delayed glitch pulse train timing engine
module glitch_pulse_gen #(
  parameter int DELAY_W = 16,
  parameter int WIDTH_W = 8,
  parameter int COUNT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        arm,
  input  logic        abort,
  input  logic        trig_in,
  output logic        glitch_out,
  output logic        armed,
  output logic        busy,
  output logic        done
);
  typedef enum logic [2:0] {IDLE, ARMED, DELAY, PULSE, GAP} state_t;
  state_t state, nxt;
  logic [DELAY_W-1:0] cfg_delay, s_delay, cnt, cnt_nxt;
  logic [WIDTH_W-1:0] cfg_width, cfg_gap, s_width, s_gap;
  logic [COUNT_W-1:0] cfg_count, s_count, rem, rem_nxt;
  logic trig_prev, rise, done_nxt, snap;
  assign rise = trig_in && !trig_prev;
  // host-visible configuration registers, writable in any state
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_delay <= '0;
      cfg_width <= WIDTH_W'(1);
      cfg_gap   <= WIDTH_W'(1);
      cfg_count <= COUNT_W'(1);
    end else if (cfg_we) begin
      if (cfg_addr == 2'd0) cfg_delay <= cfg_wdata[DELAY_W-1:0];
      if (cfg_addr == 2'd1) cfg_width <= cfg_wdata[WIDTH_W-1:0];
      if (cfg_addr == 2'd2) cfg_gap   <= cfg_wdata[WIDTH_W-1:0];
      if (cfg_addr == 2'd3) cfg_count <= cfg_wdata[COUNT_W-1:0];
    end
  end
  // snapshot taken on an accepted arm; zero width/gap/count clamp to one
  always_ff @(posedge clk) begin
    if (rst) begin
      s_delay <= '0;
      s_width <= WIDTH_W'(1);
      s_gap   <= WIDTH_W'(1);
      s_count <= COUNT_W'(1);
    end else if (snap) begin
      s_delay <= cfg_delay;
      s_width <= (cfg_width == '0) ? WIDTH_W'(1) : cfg_width;
      s_gap   <= (cfg_gap == '0) ? WIDTH_W'(1) : cfg_gap;
      s_count <= (cfg_count == '0) ? COUNT_W'(1) : cfg_count;
    end
  end
  // next-state logic; one shared down-counter serves delay, pulse and gap phases
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    rem_nxt = rem;
    done_nxt = 1'b0;
    snap = 1'b0;
    case (state)
      IDLE: if (arm) begin
        nxt = ARMED;
        snap = 1'b1;
      end
      ARMED: if (rise) begin
        nxt = DELAY;
        cnt_nxt = s_delay;
        rem_nxt = s_count;
      end
      DELAY: begin
        nxt = (cnt == '0) ? PULSE : DELAY;
        cnt_nxt = (cnt == '0) ? DELAY_W'(s_width - 1'b1) : cnt - 1'b1;
      end
      PULSE: begin
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        else if (rem > COUNT_W'(1)) begin
          nxt = GAP;
          cnt_nxt = DELAY_W'(s_gap - 1'b1);
          rem_nxt = rem - 1'b1;
        end else begin
          nxt = IDLE;
          done_nxt = 1'b1;
        end
      end
      GAP: begin
        nxt = (cnt == '0) ? PULSE : GAP;
        cnt_nxt = (cnt == '0) ? DELAY_W'(s_width - 1'b1) : cnt - 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (abort) begin
      nxt = IDLE;
      done_nxt = 1'b0;
      snap = 1'b0;
    end
  end
  // state, counters and registered outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rem <= '0;
      trig_prev <= 1'b0;
      glitch_out <= 1'b0;
      armed <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      rem <= rem_nxt;
      trig_prev <= trig_in;
      glitch_out <= (nxt == PULSE);
      armed <= (nxt == ARMED);
      busy <= (nxt == DELAY) || (nxt == PULSE) || (nxt == GAP);
      done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_glitch_pulse_gen.sv
// tb_glitch_pulse_gen: directed self-checking bench for glitch_pulse_gen
module tb_glitch_pulse_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [15:0] cfg_wdata = '0;
  logic arm = 1'b0;
  logic abort = 1'b0;
  logic trig_in = 1'b0;
  logic glitch_out, armed, busy, done;
  int checks = 0;
  int errors = 0;

  glitch_pulse_gen dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .arm(arm), .abort(abort), .trig_in(trig_in),
    .glitch_out(glitch_out), .armed(armed), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cfg_all(input int d, input int w, input int g, input int n);
    cfg(2'd0, 16'(d)); cfg(2'd1, 16'(w)); cfg(2'd2, 16'(g)); cfg(2'd3, 16'(n));
  endtask

  // arm, give one low trigger cycle, then raise trigger; returns just after edge t
  task automatic arm_trig();
    arm = 1'b1; tick(); arm = 1'b0;
    trig_in = 1'b0; tick();
    trig_in = 1'b1; tick();
    trig_in = 1'b0;
  endtask

  // records edge offsets (from t) of first glitch rise, number of high cycles and done
  task automatic measure(output int rise_k, output int high_n, output int done_k);
    logic prev = glitch_out;
    rise_k = -1; high_n = 0; done_k = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (glitch_out && !prev && rise_k < 0) rise_k = k;
      if (glitch_out) high_n++;
      if (done && done_k < 0) done_k = k;
      prev = glitch_out;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({glitch_out, armed, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000", {glitch_out, armed, busy, done});
    end
  endtask

  task automatic test_default();
    arm = 1'b1; tick(); arm = 1'b0;
    checks++;
    if (armed !== 1'b1) begin errors++; $display("FAIL default_armed got %b exp 1", armed); end
    trig_in = 1'b1; tick(); trig_in = 1'b0;
    checks++;
    if ({armed, busy, glitch_out} !== 3'b010) begin
      errors++; $display("FAIL default_t got %b exp 010", {armed, busy, glitch_out});
    end
    tick();
    checks++;
    if ({glitch_out, done} !== 2'b10) begin
      errors++; $display("FAIL default_t1 got %b exp 10", {glitch_out, done});
    end
    tick();
    checks++;
    if ({glitch_out, done, busy} !== 3'b010) begin
      errors++; $display("FAIL default_t2 got %b exp 010", {glitch_out, done, busy});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL default_done_once got %b exp 0", done); end
  endtask

  task automatic test_delay_width();
    logic eg, eb, ed;
    cfg_all(3, 2, 1, 1);
    arm_trig();
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) tick();
      eg = (k >= 4 && k <= 5);
      eb = (k <= 5);
      ed = (k == 6);
      checks++;
      if ({glitch_out, busy, done} !== {eg, eb, ed}) begin
        errors++; $display("FAIL d3w2 k=%0d got %b exp %b", k, {glitch_out, busy, done}, {eg, eb, ed});
      end
    end
  endtask

  task automatic test_train();
    logic eg, ed;
    cfg_all(0, 1, 4, 3);
    arm_trig();
    for (int k = 1; k <= 14; k++) begin
      tick();
      eg = (k == 1 || k == 6 || k == 11);
      ed = (k == 12);
      checks++;
      if ({glitch_out, done} !== {eg, ed}) begin
        errors++; $display("FAIL train k=%0d got %b exp %b", k, {glitch_out, done}, {eg, ed});
      end
    end
  endtask

  task automatic test_level_trigger();
    cfg_all(0, 1, 1, 1);
    trig_in = 1'b1; tick();
    arm = 1'b1; tick(); arm = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({armed, busy} !== 2'b10) begin
      errors++; $display("FAIL level_held got %b exp 10", {armed, busy});
    end
    trig_in = 1'b0; tick();
    trig_in = 1'b1; tick();
    checks++;
    if ({armed, busy} !== 2'b01) begin
      errors++; $display("FAIL level_rise got %b exp 01", {armed, busy});
    end
    tick();
    checks++;
    if (glitch_out !== 1'b1) begin errors++; $display("FAIL level_pulse got %b exp 1", glitch_out); end
    trig_in = 1'b0; tick(); tick();
  endtask

  task automatic test_abort();
    logic seen = 1'b0;
    cfg_all(10, 1, 1, 1);
    arm_trig();
    tick(); tick();
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({armed, busy, glitch_out, done} !== 4'b0000) begin
      errors++; $display("FAIL abort_idle got %b exp 0000", {armed, busy, glitch_out, done});
    end
    for (int k = 0; k < 15; k++) begin
      tick();
      if (glitch_out || done || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet got %b exp 0", seen); end
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    checks++;
    if (armed !== 1'b0) begin errors++; $display("FAIL arm_abort got %b exp 0", armed); end
    trig_in = 1'b1; tick(); trig_in = 1'b0; tick();
    checks++;
    if ({armed, busy} !== 2'b00) begin
      errors++; $display("FAIL arm_abort_stay got %b exp 00", {armed, busy});
    end
  endtask

  task automatic test_clamp();
    int r, h, d;
    cfg_all(0, 0, 0, 0);
    arm_trig();
    measure(r, h, d);
    checks++;
    if (r !== 1 || h !== 1 || d !== 2) begin
      errors++; $display("FAIL clamp got rise=%0d high=%0d done=%0d exp 1 1 2", r, h, d);
    end
  endtask

  task automatic test_cfg_during_delay();
    int r, h, d;
    cfg_all(5, 1, 1, 1);
    arm_trig();
    cfg(2'd0, 16'd1);
    cfg(2'd1, 16'd3);
    measure(r, h, d);
    r += 2;
    d += 2;
    checks++;
    if (r !== 6 || h !== 1 || d !== 7) begin
      errors++; $display("FAIL cfg_current got rise=%0d high=%0d done=%0d exp 6 1 7", r, h, d);
    end
    arm_trig();
    measure(r, h, d);
    checks++;
    if (r !== 2 || h !== 3 || d !== 5) begin
      errors++; $display("FAIL cfg_next got rise=%0d high=%0d done=%0d exp 2 3 5", r, h, d);
    end
  endtask

  task automatic test_back_to_back();
    int r, h, d;
    cfg_all(2, 1, 2, 2);
    arm_trig();
    measure(r, h, d);
    checks++;
    if (r !== 3 || h !== 2 || d !== 7) begin
      errors++; $display("FAIL b2b_first got rise=%0d high=%0d done=%0d exp 3 2 7", r, h, d);
    end
    arm_trig();
    measure(r, h, d);
    checks++;
    if (r !== 3 || h !== 2 || d !== 7) begin
      errors++; $display("FAIL b2b_second got rise=%0d high=%0d done=%0d exp 3 2 7", r, h, d);
    end
  endtask

  task automatic test_mid_reset();
    int r, h, d;
    cfg_all(0, 6, 1, 3);
    arm_trig();
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({glitch_out, armed, busy, done} !== 4'b0000) begin
      errors++; $display("FAIL midrst_out got %b exp 0000", {glitch_out, armed, busy, done});
    end
    arm_trig();
    measure(r, h, d);
    checks++;
    if (r !== 1 || h !== 1 || d !== 2) begin
      errors++; $display("FAIL midrst_cfg got rise=%0d high=%0d done=%0d exp 1 1 2", r, h, d);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_delay_width();
    test_train();
    test_level_trigger();
    test_abort();
    test_clamp();
    test_cfg_during_delay();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
